// File: rtl/ifetch_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, reset/step defaults and
// the instruction word width that the instruction register also uses.
package ifetch_pkg;

  localparam int          INSN_WIDTH   = 32;
  localparam int          ADDR_WIDTH   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_PC_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifetch_pc.sv
// Fetch PC register. A redirect load always beats a sequential increment;
// the increment wraps naturally at the top of the address space.
module ifetch_pc
  import ifetch_pkg::*;
#(
  parameter int                 A_WIDTH  = ADDR_WIDTH,
  parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(DEF_RESET_PC),
  parameter int                 PC_STEP  = DEF_PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [A_WIDTH-1:0] load_pc,
  input  logic               inc,
  output logic [A_WIDTH-1:0] fetch_pc
);

  // Reset to the boot address, then load on redirect or step after delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (load) begin
      fetch_pc <= load_pc;
    end else if (inc) begin
      fetch_pc <= fetch_pc + A_WIDTH'(PC_STEP);
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit. Reads one word at a time from instruction memory
// (req/gnt, then a single rvalid) and loads it into the instruction register
// with a one-cycle ir_en pulse.
//
// Handshakes: imem_req is held with a stable imem_addr until the cycle
// imem_gnt is seen high (only a redirect may change the address early);
// each grant yields exactly one imem_rvalid no earlier than the next cycle.
// On the consumer side ir_en is a one-cycle strobe; isu/pc are valid with it
// and hold until the next capture. stall=1 parks a fetched word in HOLD.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int                 D_WIDTH  = INSN_WIDTH,
  parameter int                 A_WIDTH  = ADDR_WIDTH,
  parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(DEF_RESET_PC),
  parameter int                 PC_STEP  = DEF_PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [D_WIDTH-1:0] imem_rdata,
  output logic [D_WIDTH-1:0] isu,
  output logic               ir_en,
  output logic [A_WIDTH-1:0] pc,
  output fetch_state_t       dbg_state
);

  fetch_state_t       state;
  logic               kill;
  logic [A_WIDTH-1:0] fetch_pc;
  logic [A_WIDTH-1:0] target_pc;
  logic               pc_inc;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign target_pc = redirect_pc & ~A_WIDTH'(3);

  // Step the PC only when a word is actually handed to the consumer.
  assign pc_inc = ((state == WAIT) && imem_rvalid && !kill && !redirect && !stall) ||
                  ((state == HOLD) && !redirect && !stall);

  ifetch_pc #(
    .A_WIDTH (A_WIDTH),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect),
    .load_pc (target_pc),
    .inc     (pc_inc),
    .fetch_pc(fetch_pc)
  );

  // Request side is combinational from state so the address tracks fetch_pc.
  assign imem_req  = (state == REQ);
  assign imem_addr = (state == REQ) ? fetch_pc : '0;
  assign dbg_state = state;

  // Fetch FSM with registered consumer-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      kill  <= 1'b0;
      isu   <= '0;
      pc    <= '0;
      ir_en <= 1'b0;
    end else begin
      ir_en <= 1'b0;
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (imem_gnt) begin
            state <= WAIT;
            // A redirect in the grant cycle makes the accepted read stale.
            if (redirect) kill <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill || redirect) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              isu <= imem_rdata;
              pc  <= fetch_pc;
              if (!stall) begin
                ir_en <= 1'b1;
                state <= REQ;
              end else begin
                state <= HOLD;
              end
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            state <= REQ;
          end else if (!stall) begin
            ir_en <= 1'b1;
            state <= REQ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a memory driver issues grants/read data, the
// expected {pc, isu} of every word that must reach the instruction register
// is queued, and a monitor pops and compares on every ir_en pulse.
module tb_ifetch;
  import ifetch_pkg::*;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic [31:0]  isu;
  logic         ir_en;
  logic [31:0]  pc;
  fetch_state_t dbg_state;

  logic [63:0] exp_q[$];
  int          n_checks;
  int          n_pass;
  logic        prev_ir_en;

  ifetch dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .isu        (isu),
    .ir_en      (ir_en),
    .pc         (pc),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Wait (bounded) for a request and check its address.
  task automatic wait_req(input logic [31:0] addr);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      cyc();
      n++;
    end
    chk("req_seen", imem_req, 1);
    chk("req_addr", imem_addr, addr);
  endtask

  // One normal transaction: gdly cycles before grant, rdly extra cycles
  // before rvalid, stall held stall_n cycles when the data lands.
  task automatic deliver(input logic [31:0] addr, input logic [31:0] data,
                         input int gdly, input int rdly, input int stall_n);
    wait_req(addr);
    for (int i = 0; i < gdly; i++) begin
      imem_gnt = 1'b0;
      cyc();
      chk("req_held", imem_req, 1);
      chk("addr_stable", imem_addr, addr);
    end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      chk("no_dup_req", imem_req, 0);
      cyc();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    stall       = (stall_n > 0);
    exp_q.push_back({addr, data});
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (stall_n > 0) begin
      for (int i = 0; i < stall_n; i++) begin
        chk("stall_no_ir_en", ir_en, 0);
        chk("stall_isu_held", isu, data);
        chk("stall_pc_held", pc, addr);
        cyc();
      end
      stall = 1'b0;
      cyc();
    end
    chk("ir_en_latency", ir_en, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      prev_ir_en = 1'b0;
    end else begin
      if (ir_en) begin
        chk("ir_en_single", prev_ir_en, 0);
        chk("ir_en_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("deliver_pc", pc, e[63:32]);
          chk("deliver_isu", isu, e[31:0]);
        end
      end
      prev_ir_en = ir_en;
    end
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    prev_ir_en  = 1'b0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    cyc();
    cyc();
    chk("rst_isu", isu, 0);
    chk("rst_ir_en", ir_en, 0);
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    chk("idle_no_req", imem_req, 0);

    // 1: first fetch at RESET_PC, zero wait states
    deliver(32'h0, 32'h0050_0093, 0, 0, 0);
    // 2: grant delayed 3, data delayed 2 more
    deliver(32'h4, 32'h0011_0113, 3, 2, 0);
    // 3: stall held 4 cycles over the returned word
    deliver(32'h8, 32'h0020_8193, 0, 0, 4);

    // 4: redirect while waiting for data; returning word is discarded
    wait_req(32'hC);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0001;
    cyc();
    imem_rvalid = 1'b0;
    chk("wait_redirect_drop", ir_en, 0);
    deliver(32'h100, 32'h0030_0213, 0, 0, 0);

    // 5a: redirect while a stalled word sits in HOLD
    wait_req(32'h104);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0002;
    stall       = 1'b1;
    cyc();
    imem_rvalid = 1'b0;
    chk("hold_state", dbg_state, HOLD);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("hold_redirect_drop", ir_en, 0);
    wait_req(32'h200);

    // 5b: redirect in the grant cycle kills the granted read
    imem_gnt    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    cyc();
    imem_gnt    = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0003;
    cyc();
    imem_rvalid = 1'b0;
    chk("gnt_redirect_drop", ir_en, 0);
    wait_req(32'h300);

    // 5c: misaligned redirect target while requesting
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    cyc();
    redirect = 1'b0;
    deliver(32'h200, 32'h0040_0293, 0, 1, 0);

    // 6: wrap from the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    deliver(32'hFFFF_FFFC, 32'h0050_0313, 0, 0, 0);
    wait_req(32'h0);

    // 6: reset mid-WAIT, then a late rvalid must be ignored
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    chk("pre_rst_wait", dbg_state, WAIT);
    rst = 1'b1;
    #1;
    chk("async_rst_isu", isu, 0);
    chk("async_rst_pc", pc, 0);
    chk("async_rst_ir_en", ir_en, 0);
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_addr", imem_addr, 0);
    cyc();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0004;
    cyc();
    chk("late_rvalid_idle", ir_en, 0);
    chk("post_rst_addr", imem_addr, 32'h0);
    cyc();
    imem_rvalid = 1'b0;
    chk("late_rvalid_req", ir_en, 0);
    chk("still_req", dbg_state, REQ);
    deliver(32'h0, 32'h0060_0393, 0, 0, 0);
    wait_req(32'h4);

    cyc();
    cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch unit; the producer side of the instruction-register load interface.
- Owns the fetch PC and issues word reads to instruction memory over a req/gnt + rvalid handshake.
- Delivers each fetched word on isu with a one-cycle ir_en load pulse into the instruction register.
- Supports back-pressure (stall) and control-flow redirect, including discard of an in-flight read.

Parameters:
- D_WIDTH, 32, instruction word width.
- A_WIDTH, 32, address/PC width.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  consumer cannot accept a new instruction this cycle.
- redirect  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  A_WIDTH  new fetch target; bits [1:0] are ignored (forced 00).
- imem_req  out  1  read request, held until granted.
- imem_addr  out  A_WIDTH  read address; stable while imem_req=1 and imem_gnt=0, except on redirect.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid; at most one per granted request, earliest the cycle after gnt.
- imem_rdata  in  D_WIDTH  read data.
- isu  out  D_WIDTH  instruction word to the instruction register.
- ir_en  out  1  load strobe to the instruction register; one cycle per delivered instruction.
- pc  out  A_WIDTH  address of the word currently on isu.

Behaviour:
- Reset (async): state=IDLE, fetch_pc=RESET_PC, kill=0; all outputs 0 (isu, ir_en, pc, imem_req, imem_addr).
- States: IDLE, REQ, WAIT, HOLD. Each output below is registered unless stated otherwise.
- IDLE: one cycle, no request, then REQ.
  - redirect in IDLE loads fetch_pc and still goes to REQ.
- REQ: imem_req=1, imem_addr=fetch_pc (combinational from state/fetch_pc).
  - imem_gnt=1 -> WAIT.
  - redirect=1 with no gnt: fetch_pc<=redirect_pc, stay REQ. The new address appears next cycle.
  - redirect=1 and imem_gnt=1 in the same cycle: the granted read is stale. kill<=1, fetch_pc<=redirect_pc, -> WAIT.
- WAIT: imem_req=0.
  - redirect=1: kill<=1, fetch_pc<=redirect_pc.
  - imem_rvalid=1 with kill=1, or with redirect=1 in the same cycle: discard data, kill<=0, -> REQ; no ir_en.
  - imem_rvalid=1 with kill=0 and no redirect: isu<=imem_rdata, pc<=fetch_pc.
    - stall=0: ir_en<=1, fetch_pc<=fetch_pc+PC_STEP, -> REQ.
    - stall=1: -> HOLD.
- HOLD: isu and pc held.
  - redirect=1 (priority over stall): drop the word, fetch_pc<=redirect_pc, -> REQ; no ir_en.
  - else stall=0: ir_en<=1, fetch_pc<=fetch_pc+PC_STEP, -> REQ.
- ir_en:
  - high for exactly one cycle per accepted word; never high two consecutive cycles.
  - never high for a killed or dropped word.
  - isu/pc are valid in the same cycle as ir_en and held until the next capture.
- Latency: with gnt on the first REQ cycle and rvalid the next cycle, ir_en rises 1 cycle after rvalid. Peak throughput is 1 instruction per 2 cycles.
- PC arithmetic: fetch_pc+PC_STEP wraps modulo 2^A_WIDTH (0xFFFFFFFC -> 0x00000000); no error raised.
- Reset mid-transaction: all state cleared immediately. A late imem_rvalid arriving in IDLE or REQ after reset is ignored.
- imem_rvalid outside WAIT is ignored.

Decomposition:
- Shared cpu package holds:
  - fetch state enum (IDLE, REQ, WAIT, HOLD)
  - default RESET_PC and PC_STEP constants
  - instruction width constant, shared with the instruction register
- One natural sub-module: ifetch_pc, the fetch_pc register with reset/load(redirect)/increment priority (load > increment).
- Everything else stays inline in ifetch.

Test Plan:
1. Reset release, gnt same cycle, rvalid next cycle, rdata=0x00500093, stall=0 -> imem_addr=0x0 in REQ; ir_en one cycle with isu=0x00500093, pc=0x0; next request addr=0x4.
2. Wait states: gnt delayed 3 cycles, rvalid delayed 2 more -> imem_addr stable at 0x4 throughout, single ir_en pulse, no duplicate request.
3. stall=1 when rvalid arrives, held 4 cycles -> no ir_en during stall; isu/pc held; ir_en exactly one cycle after stall drops; next addr = pc+4.
4. redirect_pc=0x100 asserted in WAIT before rvalid -> returning word discarded (no ir_en); next imem_addr=0x100; the following word delivered with pc=0x100.
5. redirect in HOLD, redirect with gnt in same cycle, and redirect_pc=0x203 -> each stale word discarded; fetch resumes at 0x200 (low bits masked).
6. fetch_pc=0xFFFFFFFC delivered -> next imem_addr=0x00000000. Assert rst mid-WAIT -> all outputs 0 immediately; first post-reset addr=RESET_PC; the stale rvalid is ignored.
